des_iter_ctrl: RTL and testbench

Iterative DES sequencing controller. It accepts one 64-bit block, a 64-bit key and a direction through a valid/ready handshake. It applies the initial permutation, runs the 16 Feistel rounds one per clock, generates the round subkeys on the fly, and applies the final permutation. The round function f (E-expansion, S-boxes, P) sits outside this block as combinational logic. This controller owns all sequencing, the L/R state and the key-schedule state between the host interface and that f-function.

---
 rtl/des_iter_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_des_iter_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_iter_ctrl.sv
// rtl/des_iter_ctrl.sv - iterative DES sequencer: IP/FP, L/R rounds and on-the-fly key schedule
// The f-function is external; this block presents R and the round subkey and consumes f_res.
module des_iter_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy,
  output logic [3:0]  round,
  output logic [31:0] f_r,
  output logic [47:0] f_key,
  input  logic [31:0] f_res
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Tables use DES numbering: entry n is bit n counted from the MSB, first entry is output MSB.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25
  };

  // PC1 never selects bits 8,16,...,64, which is what makes the parity bits irrelevant.
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    logic [5:0]  idx;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      idx = 6'(64 - IP_T[i]);
      y   = {y[62:0], x[idx]};
    end
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    logic [5:0]  idx;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      idx = 6'(64 - FP_T[i]);
      y   = {y[62:0], x[idx]};
    end
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    logic [5:0]  idx;
    y = '0;
    for (int i = 0; i < 56; i++) begin
      idx = 6'(64 - PC1_T[i]);
      y   = {y[54:0], x[idx]};
    end
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    logic [5:0]  idx;
    y = '0;
    for (int i = 0; i < 48; i++) begin
      idx = 6'(56 - PC2_T[i]);
      y   = {y[46:0], x[idx]};
    end
    return y;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] n, input logic right);
    logic [27:0] y;
    y = x;
    if (right) begin
      if (n == 2'd1) y = {x[0], x[27:1]};
      if (n == 2'd2) y = {x[1:0], x[27:2]};
    end else begin
      if (n == 2'd1) y = {x[26:0], x[27]};
      if (n == 2'd2) y = {x[25:0], x[27:26]};
    end
    return y;
  endfunction

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] l_q;
  logic [31:0] r_q;
  logic [55:0] cd_q;
  logic        decrypt_q;
  logic [63:0] out_data_q;
  logic [1:0]  rot_amt;
  logic [55:0] cd_rot;
  logic [31:0] r_next;

  // Decrypt walks the schedule backwards: round 0 uses the unrotated PC1 state (K16).
  always_comb begin
    rot_amt = 2'd2;
    if (cnt == 4'd0 || cnt == 4'd1 || cnt == 4'd8 || cnt == 4'd15) rot_amt = 2'd1;
    if (decrypt_q && cnt == 4'd0) rot_amt = 2'd0;
  end

  always_comb begin
    cd_rot = {rot28(cd_q[55:28], rot_amt, decrypt_q), rot28(cd_q[27:0], rot_amt, decrypt_q)};
    r_next = l_q ^ f_res;
  end

  assign f_key     = pc2_perm(cd_rot);
  assign f_r       = r_q;
  assign round     = (state == S_ROUND) ? cnt : 4'd0;
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign out_data  = out_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      l_q        <= '0;
      r_q        <= '0;
      cd_q       <= '0;
      decrypt_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            {l_q, r_q} <= ip_perm(in_data);
            cd_q       <= pc1_perm(in_key);
            decrypt_q  <= in_decrypt;
            cnt        <= 4'd0;
            state      <= S_ROUND;
          end
        end
        S_ROUND: begin
          l_q  <= r_q;
          r_q  <= r_next;
          cd_q <= cd_rot;
          cnt  <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            // Final swap is undone here: FP is applied to {R16, L16}.
            out_data_q <= fp_perm({r_next, r_q});
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_iter_ctrl.sv
// tb/tb_des_iter_ctrl.sv - scoreboard bench for des_iter_ctrl with a software DES model
module tb_des_iter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] in_key;
  logic        in_decrypt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;
  logic [3:0]  round;
  logic [31:0] f_r;
  logic [47:0] f_key;
  logic [31:0] f_res;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] CT  = 64'h85E813540F0AB405;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [255:0] SBOX [8] = '{
    256'he4d12fb83a6c59070f74e2d1a6cb953841e8d62bfc973a50fc8249175b3ea06d,
    256'hf18e6b34972dc05a3d47f28ec01a69b50e7ba4d158c6932fd8a13f42b67c05e9,
    256'ha09e63f51dc7b428d70934a6285ecbf1d6498f30b12c5ae71ad069874fe3b52c,
    256'h7de3069a1285bc4fd8b56f03472c1ae9a690cb7df13e52843f06a1d8945bc72e,
    256'h2c417ab6853fd0e9eb2c47d150fa3986421bad78f9c5630eb8c71e2d6f09a453,
    256'hc1af92680d34e75baf427c9561de0b389ef528c3704a1db6432c95fabe17608d,
    256'h4b2ef08d3c975a61d0b7491ae35c2f8614bdc37eaf6805926bd814a7950fe23c,
    256'hd2846fb1a93e50c71fd8a374c56b0e927b419ce206adf35821e74a8dfc90356b};

  function automatic logic [63:0] perm64(input logic [63:0] x, input bit use_fp);
    logic [63:0] y = '0;
    for (int i = 0; i < 64; i++) y = {y[62:0], x[64 - (use_fp ? FP_T[i] : IP_T[i])]};
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] y = '0;
    for (int i = 0; i < 56; i++) y = {y[54:0], x[64 - PC1_T[i]]};
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] y = '0;
    for (int i = 0; i < 48; i++) y = {y[46:0], x[56 - PC2_T[i]]};
    return y;
  endfunction

  function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
    logic [47:0]  e = '0;
    logic [31:0]  s = '0;
    logic [31:0]  p = '0;
    logic [5:0]   b;
    logic [255:0] sb;
    int           pos;
    for (int i = 0; i < 48; i++) e = {e[46:0], r[32 - E_T[i]]};
    e = e ^ k;
    for (int i = 0; i < 8; i++) begin
      b   = e[47 - 6*i -: 6];
      pos = int'({b[5], b[0]}) * 16 + int'(b[4:1]);
      sb  = SBOX[i] >> (4 * (63 - pos));
      s   = {s[27:0], sb[3:0]};
    end
    for (int i = 0; i < 32; i++) p = {p[30:0], s[32 - P_T[i]]};
    return p;
  endfunction

  // Subkey K(n+1): cumulative left rotations from PC1, independent of the DUT's right-rotate path.
  function automatic logic [47:0] subkey(input logic [63:0] key, input int n);
    logic [55:0] cd = pc1(key);
    logic [27:0] c = cd[55:28];
    logic [27:0] d = cd[27:0];
    for (int j = 0; j <= n; j++)
      for (int s = 0; s < SH_T[j]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
    return pc2({c, d});
  endfunction

  function automatic logic [63:0] des_model(input logic [63:0] data, input logic [63:0] key, input bit dec);
    logic [63:0] lr = perm64(data, 1'b0);
    logic [31:0] l = lr[63:32];
    logic [31:0] r = lr[31:0];
    logic [31:0] t;
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ f_func(r, subkey(key, dec ? 15 - i : i));
      l = t;
    end
    return perm64({r, l}, 1'b1);
  endfunction

  assign f_res = f_func(f_r, f_key);

  des_iter_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .in_decrypt(in_decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .round(round), .f_r(f_r), .f_key(f_key), .f_res(f_res)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [63:0] exp_q[$];
  logic [63:0] last_out;
  int          hs_count = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic        ov_d = 1'b0;
  int          log_mode = 0;
  logic [47:0] ks_enc [16];
  logic [47:0] ks_dec [16];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [63:0] e;
    if (in_valid && in_ready) acc_cyc = cyc + 1;
    if (out_valid && !ov_d) begin
      chk("latency_edges", 64'(cyc - acc_cyc), 64'd16);
      chk("in_ready_with_out_valid", 64'(in_ready), 64'd0);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %h expected none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e);
      end
      last_out = out_data;
      hs_count++;
    end
    ov_d = out_valid;
  end

  always @(negedge clk) begin
    if (log_mode == 1 && busy && !out_valid) ks_enc[round] = f_key;
    if (log_mode == 2 && busy && !out_valid) ks_dec[round] = f_key;
  end

  task automatic drive(input logic [63:0] d, input logic [63:0] k, input logic dec,
                       input bit push, input logic [63:0] exp);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      fails++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
      return;
    end
    if (push) exp_q.push_back(exp);
    in_valid = 1'b1; in_data = d; in_key = k; in_decrypt = dec;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_hs();
    int start = hs_count;
    int n = 0;
    while (hs_count == start && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (hs_count == start) begin
      fails++;
      $display("FAIL handshake_timeout: got none expected out_valid");
    end
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid_arrives", 64'(out_valid), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d, k, e;
    logic        m;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_key = '0; in_decrypt = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_round", 64'(round), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_f_r", 64'(f_r), 64'd0);
    chk("rst_f_key", 64'(f_key), 64'd0);

    // Round trip on the classic vector, feeding the DUT's own ciphertext back in.
    drive(PT, KEY, 1'b0, 1'b1, CT);
    wait_hs();
    drive(last_out, KEY, 1'b1, 1'b1, PT);
    wait_hs();

    // Subkey logging combined with back-pressure on the encrypt run.
    log_mode = 1;
    out_ready = 1'b0;
    drive(PT, KEY, 1'b0, 1'b1, CT);
    wait_out_valid();
    chk("cd_after_last_round", 64'(dut.cd_q), 64'(pc1(KEY)));
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_data", out_data, CT);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0000_0000 | 64'(i); in_key = '0; in_decrypt = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    log_mode = 2;
    drive(CT, KEY, 1'b1, 1'b1, PT);
    wait_hs();
    log_mode = 0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("subkey_enc_%0d", i), 64'(ks_enc[i]), 64'(subkey(KEY, i)));
      chk($sformatf("subkey_rev_%0d", i), 64'(ks_dec[i]), 64'(ks_enc[15 - i]));
    end

    // Reset in the middle of round 7: block is lost, next block is correct.
    drive(64'hFEDCBA9876543210, KEY, 1'b0, 1'b0, 64'd0);
    for (int n = 0; n < 40 && round != 4'd7; n++) begin
      @(posedge clk); #1;
    end
    chk("reached_round_7", 64'(round), 64'd7);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_round", 64'(round), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    chk("midrst_f_r", 64'(f_r), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    drive(PT, KEY, 1'b0, 1'b1, CT);
    wait_hs();

    // Parity bits flipped: same ciphertext.
    drive(PT, KEY ^ 64'h0101010101010101, 1'b0, 1'b1, CT);
    wait_hs();
    drive(64'h0011223344556677, 64'h0E329232EA6D0D73 ^ 64'h0101010101010101, 1'b0, 1'b1,
          des_model(64'h0011223344556677, 64'h0E329232EA6D0D73, 1'b0));
    wait_hs();

    // Golden model sweep with inverse round trip for each case.
    for (int i = 0; i < 200; i++) begin
      d = {$urandom, $urandom};
      k = {$urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      e = des_model(d, k, m);
      drive(d, k, m, 1'b1, e);
      wait_hs();
      drive(last_out, k, ~m, 1'b1, d);
      wait_hs();
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
